// File: rtl/aes_package.sv
// Shared types and constants for the AES stream packer.
// Holds the packer FSM state encoding and the AES block width.
// No logic; imported by aes_stream_packer.
package aes_package;

    localparam int AES_BLOCK_W = 128;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_CT = 2'd2,
        DRAIN   = 2'd3
    } aes_packer_state_t;

endpackage

// File: rtl/aes_byteswap.sv
// Purpose: reverse the byte order of a W-bit word (byte 0 <-> byte W/8-1).
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake, output follows input.
// Ports: din (W) word in, dout (W) byte-reversed word out. W must be a multiple of 8.
module aes_byteswap #(
    parameter int W = 32
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    localparam int NB = W / 8;

    for (genvar b = 0; b < NB; b++) begin : g_byte
        assign dout[8*b +: 8] = din[8*(NB-1-b) +: 8];
    end

endmodule

// File: rtl/aes_stream_packer.sv
// Purpose: pack N_WORDS stream words into one 128-bit block for the cipher core,
//          then unpack the returned ciphertext block back into stream words.
// Latency: blk_valid rises the cycle after the last input word; out_valid rises
//          the cycle after the ciphertext transfer.
// Backpressure: blk_ready / out_ready low stall the FSM indefinitely with outputs
//          held stable; in_ready and ct_ready are driven from state only.
//
// Ports:
//   clk, reset_n (sync, active-low), clear (sync soft clear, same effect as reset)
//   in_data/in_valid/in_ready     source word stream
//   blk_data/blk_valid/blk_ready  plaintext block to the core
//   ct_data/ct_valid/ct_ready     ciphertext block from the core
//   out_data/out_valid/out_ready  ciphertext word stream to the sink
//   word_cnt                      index of the next word to accept or emit
//   busy                          low only when idle in FILL with no words held
//
// Build option: define AES_PACKER_BYTESWAP_EN to byte-reverse each word on the
// way in (before storage) and on the way out.
//
// WORD_W * N_WORDS must equal AES_BLOCK_W; word_cnt is 2 bits, so N_WORDS <= 4.
module aes_stream_packer
    import aes_package::*;
#(
    parameter int WORD_W  = 32,
    parameter int N_WORDS = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,

    input  logic [WORD_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,

    output logic [AES_BLOCK_W-1:0] blk_data,
    output logic                   blk_valid,
    input  logic                   blk_ready,

    input  logic [AES_BLOCK_W-1:0] ct_data,
    input  logic                   ct_valid,
    output logic                   ct_ready,

    output logic [WORD_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,

    output logic [1:0]             word_cnt,
    output logic                   busy
);

    localparam logic [1:0] LAST_IDX = 2'(N_WORDS - 1);

    aes_packer_state_t        state;
    aes_packer_state_t        state_nxt;
    logic [1:0]               cnt;
    logic [1:0]               cnt_nxt;
    logic [AES_BLOCK_W-1:0]   blk;

    logic [WORD_W-1:0]        in_word;   // input word as it is stored
    logic [WORD_W-1:0]        sel_word;  // stored word at the current index
    logic                     in_xfer;
    logic                     ct_xfer;
    logic                     blk_xfer;
    logic                     out_xfer;

    // ------------------------------------------------------------------
    // Optional byte reversal on both word boundaries
    // ------------------------------------------------------------------
`ifdef AES_PACKER_BYTESWAP_EN
    aes_byteswap #(.W(WORD_W)) u_swap_in (
        .din  (in_data),
        .dout (in_word)
    );

    aes_byteswap #(.W(WORD_W)) u_swap_out (
        .din  (sel_word),
        .dout (out_data)
    );
`else
    assign in_word  = in_data;
    assign out_data = sel_word;
`endif

    assign sel_word = blk[int'(cnt)*WORD_W +: WORD_W];

    // Handshakes qualified by the state-only ready/valid outputs.
    assign in_xfer  = in_valid  & in_ready;
    assign blk_xfer = blk_valid & blk_ready;
    assign ct_xfer  = ct_valid  & ct_ready;
    assign out_xfer = out_valid & out_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            state <= FILL;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs. Ready/valid depend on state only, so
    // there is no combinational path from in_valid to in_ready.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        blk_valid = 1'b0;
        ct_ready  = 1'b0;
        out_valid = 1'b0;

        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (cnt == LAST_IDX) begin
                        cnt_nxt   = 2'd0;
                        state_nxt = ISSUE;
                    end else begin
                        cnt_nxt = cnt + 2'd1;
                    end
                end
            end
            ISSUE: begin
                blk_valid = 1'b1;
                if (blk_ready) begin
                    state_nxt = WAIT_CT;
                end
            end
            WAIT_CT: begin
                ct_ready = 1'b1;
                if (ct_valid) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (cnt == LAST_IDX) begin
                        cnt_nxt   = 2'd0;
                        state_nxt = FILL;
                    end else begin
                        cnt_nxt = cnt + 2'd1;
                    end
                end
            end
            default: begin
                state_nxt = FILL;
                cnt_nxt   = 2'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Block register: filled word by word, then overwritten in one go by
    // the ciphertext so the drain reuses the same storage and index.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            blk <= '0;
        end else if (in_xfer) begin
            blk[int'(cnt)*WORD_W +: WORD_W] <= in_word;
        end else if (ct_xfer) begin
            blk <= ct_data;
        end
    end

    assign blk_data = blk;
    assign word_cnt = cnt;
    assign busy     = !((state == FILL) && (cnt == 2'd0));

    // Block and sink handshakes only steer the FSM; no datapath effect.
    logic unused_xfer;
    assign unused_xfer = blk_xfer ^ out_xfer;

endmodule
